// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Fetch stage in front of the opcode decoder. Owns the PC, fetches 32-bit
//   words from instruction memory over a req/ack handshake and hands each
//   word, with its PC, to decode through if_valid/stall. A one-entry skid
//   buffer catches a word that returns while decode is stalled. redirect
//   steers the PC on a taken branch/jump.
//
//   Optional feature: define FETCH_OPCODE_CHECK_EN to register an
//   illegal-opcode flag alongside each delivered word. Without it,
//   if_illegal is tied low.
//
// Ports
//   clk, rst_n       clock (rising edge), asynchronous active-low reset
//   imem_req/addr    fetch request and address (registered sources only)
//   imem_ack/rdata   completion and instruction word
//   redirect_valid   refetch from redirect_pc (beats stall and ack)
//   stall            decode cannot accept; outputs hold
//   if_valid/instr/pc/op/illegal   word presented to decode
//
// state | meaning
// ------+-----------------------------------------------------------
// FETCH | request outstanding at pc (once out of reset)
// FULL  | output and skid both occupied, no request
// DRAIN | request at a stale address in flight after redirect; data dropped
// -----------------------------------------------------------------------------
module instr_fetch #(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = '0,
    parameter int                PC_STEP  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    output logic              imem_req,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic              imem_ack,
    input  logic [31:0]       imem_rdata,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    input  logic              stall,
    output logic              if_valid,
    output logic [31:0]       if_instr,
    output logic [ADDR_W-1:0] if_pc,
    output logic [5:0]        if_op,
    output logic              if_illegal
);

    typedef enum logic [1:0] {
        ST_FETCH = 2'd0,
        ST_FULL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic              req_en;      // holds off the first request until after reset release
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] drain_addr;
    logic [31:0]       skid_instr;
    logic [ADDR_W-1:0] skid_pc;

    logic              ack_taken;
    logic              out_free;
    logic              load_fetch;
    logic              load_skid;
    logic              fill_skid;
    logic              drop_out;
    logic [31:0]       load_instr;
    logic [ADDR_W-1:0] load_pc;
    logic [ADDR_W-1:0] pc_inc;

    assign ack_taken  = imem_req && imem_ack;
    assign out_free   = !if_valid || !stall;
    assign pc_inc     = pc + ADDR_W'(PC_STEP);

    assign load_fetch = !redirect_valid && (state == ST_FETCH) && ack_taken && out_free;
    assign fill_skid  = !redirect_valid && (state == ST_FETCH) && ack_taken && !out_free;
    assign load_skid  = !redirect_valid && (state == ST_FULL) && !stall;
    assign drop_out   = redirect_valid || (if_valid && !stall && !load_fetch && !load_skid);

    assign load_instr = load_skid ? skid_instr : imem_rdata;
    assign load_pc    = load_skid ? skid_pc    : pc;

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_FETCH;
        end else begin
            state <= state_nxt;
        end
    end

    // next state
    always_comb begin
        state_nxt = state;
        case (state)
            ST_FETCH: begin
                if (redirect_valid) begin
                    // An unacked request must finish before the new target goes out.
                    state_nxt = (imem_req && !imem_ack) ? ST_DRAIN : ST_FETCH;
                end else if (fill_skid) begin
                    state_nxt = ST_FULL;
                end
            end
            ST_FULL: begin
                if (redirect_valid || !stall) begin
                    state_nxt = ST_FETCH;
                end
            end
            ST_DRAIN: begin
                // The stale request completes on ack even if another redirect lands.
                if (imem_ack) begin
                    state_nxt = ST_FETCH;
                end
            end
            default: state_nxt = ST_FETCH;
        endcase
    end

    // outputs: decoded from registers only
    always_comb begin
        imem_req  = req_en && (state != ST_FULL);
        imem_addr = (state == ST_DRAIN) ? drain_addr : pc;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req_en     <= 1'b0;
            pc         <= RESET_PC;
            drain_addr <= RESET_PC;
            skid_instr <= '0;
            skid_pc    <= '0;
            if_valid   <= 1'b0;
            if_instr   <= '0;
            if_pc      <= '0;
        end else begin
            req_en <= 1'b1;

            if (redirect_valid) begin
                pc <= redirect_pc;
            end else if ((state == ST_FETCH) && ack_taken) begin
                pc <= pc_inc;
            end

            if (redirect_valid && (state == ST_FETCH)) begin
                drain_addr <= pc;
            end

            if (fill_skid) begin
                skid_instr <= imem_rdata;
                skid_pc    <= pc;
            end

            if (load_fetch || load_skid) begin
                if_valid <= 1'b1;
                if_instr <= load_instr;
                if_pc    <= load_pc;
            end else if (drop_out) begin
                if_valid <= 1'b0;
            end
        end
    end

    assign if_op = if_instr[31:26];

`ifdef FETCH_OPCODE_CHECK_EN
    function automatic logic op_illegal(input logic [5:0] op);
        case (op)
            6'd0, 6'd1, 6'd2, 6'd3, 6'd4,
            6'd10, 6'd11, 6'd12, 6'd13, 6'd14,
            6'd20, 6'd21, 6'd30, 6'd31: op_illegal = 1'b0;
            default:                    op_illegal = 1'b1;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            if_illegal <= 1'b0;
        end else if (load_fetch || load_skid) begin
            if_illegal <= op_illegal(load_instr[31:26]);
        end else if (drop_out) begin
            if_illegal <= 1'b0;
        end
    end
`else
    assign if_illegal = 1'b0;
`endif

endmodule
